mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It holds the EX/MEM pipeline register, drives loads and stores to the data memory over a req/ack handshake, and holds the pipeline while an access is pending.
- It aligns store data and byte enables, sign- or zero-extends load data, detects misaligned accesses, and loads the MEM/WB register consumed by write-back.

Parameters:
- TIMEOUT, 16: cycles WAIT may last without dm_ack before the access is aborted as a bus error (must be at least 2).
- CNT_W, 5: width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- clk  in  1  clock; all registers update on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_flush  in  1  loads a bubble into EX/MEM instead of the execute-stage outputs.
- Branch, MemtoReg, RegWrite, mtc0, mfc0  in  1 each  control bits from the execute stage.
- MemWrite  in  2  00 none, 01 sb, 10 sh, 11 sw.
- MemRead  in  3  000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw; 110 and 111 are treated as none.
- Aluout  in  32  effective address or ALU result.
- busB  in  32  store data.
- rd  in  5  destination register.
- overflow  in  1  ALU overflow flag.
- dm_req  out  1  access request.
- dm_we  out  1  1 = store.
- dm_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-aligned store data.
- dm_rdata  in  32  load data, valid when dm_ack = 1.
- dm_ack  in  1  access complete.
- mem_stall  out  1  freeze all upstream stages this cycle.
- MemtoReg_out, RegWrite_out  out  1 each  MEM/WB control bits.
- rd_out  out  5  MEM/WB destination register.
- Aluout_out  out  32  MEM/WB ALU result.
- memdata_out  out  32  MEM/WB extended load data.
- mtc0_out, mfc0_out  out  1 each  MEM/WB copies of mtc0/mfc0.
- adel, ades, bus_err  out  1 each  one-cycle exception pulses, registered with MEM/WB.

Behaviour:
- Reset (reset = 0, asynchronous):
  - EX/MEM and MEM/WB are cleared; every output listed above is 0.
  - FSM goes to IDLE and the counter to 0.
  - An access in flight is abandoned: dm_req drops immediately.
- EX/MEM register:
  - Loads the stage inputs on each edge where mem_stall = 0.
  - When mem_flush = 1 on that edge it loads all zeros (bubble).
  - Holds its value while mem_stall = 1.
- Memory operation and alignment:
  - memop = (MemWrite != 00) or (MemRead in 001..101), evaluated on the EX/MEM contents.
  - Misaligned: half access with addr[0] = 1, or word access with addr[1:0] != 00.
  - A misaligned access never asserts dm_req and completes in 1 cycle.
  - Misaligned effects: RegWrite_out = 0, memdata_out = 0, adel = 1 for loads, ades = 1 for stores.
- Store alignment:
  - sb: dm_be = 0001 << addr[1:0], byte replicated in all four lanes.
  - sh: dm_be = 0011 << addr[1:0], half replicated in both lanes.
  - sw: dm_be = 1111.
  - Loads: dm_be = 1111, dm_we = 0.
- Load extension: select the byte or half by addr[1:0], then sign-extend (lb, lh) or zero-extend (lbu, lhu).
- FSM, IDLE:
  - With no memop, or a misaligned memop: mem_stall = 0 and MEM/WB loads on the next edge (1-cycle latency).
  - With an aligned memop: dm_req = 1 combinationally.
  - If dm_ack = 1 in the same cycle: complete, stall = 0.
  - Otherwise: mem_stall = 1, go to WAIT, counter = 1.
- FSM, WAIT:
  - dm_req, dm_we, dm_addr, dm_be and dm_wdata are held stable.
  - mem_stall = !dm_ack.
  - On dm_ack: complete and return to IDLE.
  - If the counter reaches TIMEOUT without dm_ack: abort. Effects: dm_req drops, bus_err = 1, RegWrite_out = 0, memdata_out = 0, stall released that cycle, return to IDLE.
  - Otherwise the counter increments each cycle.
- Completion: MEM/WB captures the EX/MEM contents (rd, Aluout, controls) plus memdata_out. dm_rdata is sampled only on the dm_ack cycle.
- Stall and flush interaction:
  - While stalled, MEM/WB loads a bubble (RegWrite_out = 0), so write-back never repeats an instruction.
  - mem_flush during a stall has no effect: the pending access always completes or times out.
- Simultaneous dm_ack and timeout in the same cycle: the ack wins.
- dm_ack while dm_req = 0 is ignored.

Test Plan:
- Reset released, then an add result 0x0000_0005 with RegWrite = 1 and rd = 3 → one cycle later RegWrite_out = 1, rd_out = 3, Aluout_out = 5; dm_req never asserts.
- sb at addr 0x1003 with busB = 0x0000_00A5, dm_ack 2 cycles late → dm_be = 1000, dm_wdata = 0xA5A5A5A5, dm_addr = 0x1000, mem_stall high for 2 cycles, then released.
- lb at 0x2002 with dm_rdata = 0x0080_0000, immediate ack → memdata_out = 0xFFFF_FF80. Same access as lbu → 0x0000_0080. lh at 0x2002 with dm_rdata = 0x8001_0000 → 0xFFFF_8001.
- lw at 0x2001 → adel = 1, RegWrite_out = 0, dm_req = 0, no stall. sh at 0x2003 → ades = 1.
- lw with dm_ack held low and TIMEOUT = 16 → mem_stall high for exactly 16 cycles, bus_err pulses for 1 cycle, RegWrite_out = 0, next instruction proceeds.
- reset pulsed low during WAIT → dm_req and all outputs drop to 0 asynchronously; after release the first instruction behaves normally. mem_flush asserted during a stall → the pending access still completes.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: EX/MEM register, data-memory handshake, MEM/WB register
//
// Purpose: captures execute-stage results, issues aligned loads/stores to the
// data memory over a req/ack handshake, stalls upstream while an access is
// outstanding, extends load data and flags misaligned or timed-out accesses.
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   mem_flush                       load a bubble into EX/MEM
//   Branch .. overflow              execute-stage outputs (EX/MEM inputs)
//   dm_req/we/addr/be/wdata         data-memory request (outputs)
//   dm_rdata, dm_ack                data-memory response (inputs)
//   mem_stall                       freeze upstream stages this cycle
//   *_out, adel, ades, bus_err      MEM/WB register contents
module mem_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_flush,
   input  logic        Branch,
   input  logic        MemtoReg,
   input  logic        RegWrite,
   input  logic        mtc0,
   input  logic        mfc0,
   input  logic [1:0]  MemWrite,
   input  logic [2:0]  MemRead,
   input  logic [31:0] Aluout,
   input  logic [31:0] busB,
   input  logic [4:0]  rd,
   input  logic        overflow,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        mem_stall,
   output logic        MemtoReg_out,
   output logic        RegWrite_out,
   output logic [4:0]  rd_out,
   output logic [31:0] Aluout_out,
   output logic [31:0] memdata_out,
   output logic        mtc0_out,
   output logic        mfc0_out,
   output logic        adel,
   output logic        ades,
   output logic        bus_err
);

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   typedef struct packed {
      logic        memtoreg;
      logic        regwrite;
      logic        mtc0;
      logic        mfc0;
      logic [1:0]  memwrite;
      logic [2:0]  memread;
      logic [31:0] aluout;
      logic [31:0] busb;
      logic [4:0]  rd;
   } exmem_t;

   typedef struct packed {
      logic        memtoreg;
      logic        regwrite;
      logic        mtc0;
      logic        mfc0;
      logic [4:0]  rd;
      logic [31:0] aluout;
      logic [31:0] memdata;
      logic        adel;
      logic        ades;
      logic        bus_err;
   } memwb_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   exmem_t           exm_q, exm_d;
   memwb_t           mwb_q, mwb_d;

   logic        is_store, is_load, is_half, is_word, memop, misal, access;
   logic        abort, complete;
   logic [1:0]  a_lo;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // Branch and overflow are consumed upstream; this stage does not use them.
   logic unused_ex_inputs;
   assign unused_ex_inputs = Branch ^ overflow;

   // ---------------- access decode on EX/MEM contents ----------------
   assign a_lo     = exm_q.aluout[1:0];
   assign is_store = (exm_q.memwrite != 2'b00);
   // A store encoding takes precedence if both fields are set.
   assign is_load  = !is_store && (exm_q.memread != 3'd0) && (exm_q.memread <= 3'd5);
   assign is_half  = is_store ? (exm_q.memwrite == 2'b10)
                              : (exm_q.memread == 3'd3 || exm_q.memread == 3'd4);
   assign is_word  = is_store ? (exm_q.memwrite == 2'b11) : (exm_q.memread == 3'd5);
   assign memop    = is_store | is_load;
   assign misal    = memop && ((is_half && a_lo[0]) || (is_word && a_lo != 2'b00));
   assign access   = memop && !misal;

   // ---------------- handshake FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dm_req  = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               dm_req = 1'b1;
               if (!dm_ack) begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         S_WAIT: begin
            // EX/MEM is frozen while here, so the request fields stay stable.
            // An ack in the timeout cycle still completes the access.
            if (dm_ack) begin
               dm_req  = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == TMO) begin
               abort   = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               dm_req = 1'b1;
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign mem_stall = dm_req & ~dm_ack;
   assign complete  = dm_req & dm_ack;

   // ---------------- request fields (zero when idle) ----------------
   always_comb begin
      dm_we    = dm_req & is_store;
      dm_addr  = dm_req ? {exm_q.aluout[31:2], 2'b00} : 32'd0;
      dm_be    = 4'b0000;
      dm_wdata = 32'd0;
      if (dm_req) begin
         if (is_store) begin
            case (exm_q.memwrite)
               2'b01: begin
                  dm_be    = 4'b0001 << a_lo;
                  dm_wdata = {4{exm_q.busb[7:0]}};
               end
               2'b10: begin
                  dm_be    = 4'b0011 << a_lo;
                  dm_wdata = {2{exm_q.busb[15:0]}};
               end
               default: begin
                  dm_be    = 4'b1111;
                  dm_wdata = exm_q.busb;
               end
            endcase
         end else begin
            dm_be = 4'b1111;
         end
      end
   end

   // ---------------- load lane select and extension ----------------
   always_comb begin
      case (a_lo)
         2'd0:    ld_byte = dm_rdata[7:0];
         2'd1:    ld_byte = dm_rdata[15:8];
         2'd2:    ld_byte = dm_rdata[23:16];
         default: ld_byte = dm_rdata[31:24];
      endcase
      ld_half = a_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (exm_q.memread)
         3'd1:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'd2:    ld_ext = {24'd0, ld_byte};
         3'd3:    ld_ext = {{16{ld_half[15]}}, ld_half};
         3'd4:    ld_ext = {16'd0, ld_half};
         3'd5:    ld_ext = dm_rdata;
         default: ld_ext = 32'd0;
      endcase
   end

   // ---------------- EX/MEM register ----------------
   always_comb begin
      exm_d = exm_q;
      if (!mem_stall) begin
         if (mem_flush) begin
            exm_d = '0;
         end else begin
            exm_d.memtoreg = MemtoReg;
            exm_d.regwrite = RegWrite;
            exm_d.mtc0     = mtc0;
            exm_d.mfc0     = mfc0;
            exm_d.memwrite = MemWrite;
            exm_d.memread  = MemRead;
            exm_d.aluout   = Aluout;
            exm_d.busb     = busB;
            exm_d.rd       = rd;
         end
      end
   end

   // ---------------- MEM/WB register ----------------
   // A stalled cycle writes a bubble so write-back never repeats an instruction.
   always_comb begin
      mwb_d = '0;
      if (!mem_stall) begin
         mwb_d.memtoreg = exm_q.memtoreg;
         mwb_d.regwrite = exm_q.regwrite & ~misal & ~abort;
         mwb_d.mtc0     = exm_q.mtc0;
         mwb_d.mfc0     = exm_q.mfc0;
         mwb_d.rd       = exm_q.rd;
         mwb_d.aluout   = exm_q.aluout;
         mwb_d.memdata  = (complete && is_load) ? ld_ext : 32'd0;
         mwb_d.adel     = misal & is_load;
         mwb_d.ades     = misal & is_store;
         mwb_d.bus_err  = abort;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exm_q <= '0;
         mwb_q <= '0;
      end else begin
         exm_q <= exm_d;
         mwb_q <= mwb_d;
      end
   end

   assign MemtoReg_out = mwb_q.memtoreg;
   assign RegWrite_out = mwb_q.regwrite;
   assign mtc0_out     = mwb_q.mtc0;
   assign mfc0_out     = mwb_q.mfc0;
   assign rd_out       = mwb_q.rd;
   assign Aluout_out   = mwb_q.aluout;
   assign memdata_out  = mwb_q.memdata;
   assign adel         = mwb_q.adel;
   assign ades         = mwb_q.ades;
   assign bus_err      = mwb_q.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking testbench for mem_stage
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_flush, Branch, MemtoReg, RegWrite, mtc0, mfc0, overflow;
   logic [1:0]  MemWrite;
   logic [2:0]  MemRead;
   logic [31:0] Aluout, busB, dm_rdata;
   logic [4:0]  rd;
   logic        dm_ack;
   logic        dm_req, dm_we, mem_stall;
   logic [31:0] dm_addr, dm_wdata, Aluout_out, memdata_out;
   logic [3:0]  dm_be;
   logic        MemtoReg_out, RegWrite_out, mtc0_out, mfc0_out, adel, ades, bus_err;
   logic [4:0]  rd_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .mem_flush(mem_flush), .Branch(Branch),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .mtc0(mtc0), .mfc0(mfc0),
      .MemWrite(MemWrite), .MemRead(MemRead), .Aluout(Aluout), .busB(busB),
      .rd(rd), .overflow(overflow), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .dm_ack(dm_ack), .mem_stall(mem_stall), .MemtoReg_out(MemtoReg_out),
      .RegWrite_out(RegWrite_out), .rd_out(rd_out), .Aluout_out(Aluout_out),
      .memdata_out(memdata_out), .mtc0_out(mtc0_out), .mfc0_out(mfc0_out),
      .adel(adel), .ades(ades), .bus_err(bus_err)
   );

   typedef struct {
      string       name;
      logic        flush;
      logic        flush_stall;
      logic        m2r;
      logic        rw;
      logic [1:0]  c0;
      logic [1:0]  mw;
      logic [2:0]  mr;
      logic [31:0] alu;
      logic [31:0] busb;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          lat;
      logic        e_req;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      int          e_st;
      logic        e_rw;
      logic [31:0] e_md;
      logic [2:0]  e_exc;
   } vec_t;

   vec_t tbl[$];
   vec_t sb_q[$];

   function automatic vec_t mk(input string nm, input logic fl, input logic fls,
                               input logic m2r, input logic rw, input logic [1:0] c0,
                               input logic [1:0] mw, input logic [2:0] mr,
                               input logic [31:0] alu, input logic [31:0] busb,
                               input logic [4:0] rdv, input logic [31:0] rdata, input int lat,
                               input logic e_req, input logic [3:0] e_be, input logic [31:0] e_wd,
                               input int e_st, input logic e_rw, input logic [31:0] e_md,
                               input logic [2:0] e_exc);
      vec_t v;
      v.name = nm; v.flush = fl; v.flush_stall = fls; v.m2r = m2r; v.rw = rw; v.c0 = c0;
      v.mw = mw; v.mr = mr; v.alu = alu; v.busb = busb; v.rd = rdv; v.rdata = rdata;
      v.lat = lat; v.e_req = e_req; v.e_be = e_be; v.e_wd = e_wd; v.e_st = e_st;
      v.e_rw = e_rw; v.e_md = e_md; v.e_exc = e_exc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive_bubble(input logic fl);
      mem_flush = fl;
      Branch = 1'b0; overflow = 1'b0; mtc0 = 1'b0; mfc0 = 1'b0; MemtoReg = 1'b0;
      busB = 32'd0; MemRead = 3'd0;
      if (fl) begin
         // Garbage that would be visible if the flush leaked into a held EX/MEM.
         RegWrite = 1'b1; rd = 5'd31; Aluout = 32'hFFFF_FFFF; MemWrite = 2'b11;
      end else begin
         RegWrite = 1'b0; rd = 5'd0; Aluout = 32'd0; MemWrite = 2'b00;
      end
   endtask

   task automatic run_op(input vec_t v);
      logic [31:0] ea;
      vec_t        e;
      int          stalls;
      bit          done;
      bit          req_now;
      ea = v.alu & 32'hFFFF_FFFC;
      @(negedge clk);
      mem_flush = v.flush; MemtoReg = v.m2r; RegWrite = v.rw;
      mtc0 = v.c0[1]; mfc0 = v.c0[0]; MemWrite = v.mw; MemRead = v.mr;
      Aluout = v.alu; busB = v.busb; rd = v.rd;
      Branch = 1'($urandom); overflow = 1'($urandom);
      sb_q.push_back(v);
      @(posedge clk); #1;
      drive_bubble(v.flush_stall);
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         dm_ack   = (v.lat == c);
         dm_rdata = dm_ack ? v.rdata : 32'hDEAD_BEEF;
         #1;
         req_now = v.e_req && !(v.e_exc[0] && c == v.e_st);
         chk({v.name, ".dm_req"}, 32'(dm_req), 32'(req_now));
         if (req_now) begin
            chk({v.name, ".dm_we"}, 32'(dm_we), 32'(v.mw != 2'b00));
            chk({v.name, ".dm_addr"}, dm_addr, ea);
            chk({v.name, ".dm_be"}, 32'(dm_be), 32'(v.e_be));
            if (v.mw != 2'b00) chk({v.name, ".dm_wdata"}, dm_wdata, v.e_wd);
         end
         if (c > 0) chk({v.name, ".stall_bubble"}, 32'(RegWrite_out), 32'd0);
         if (mem_stall) stalls++;
         else done = 1'b1;
         @(posedge clk); #1;
         dm_ack = 1'b0;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL %s.complete: stall never released within 40 cycles", v.name);
      end
      chk({v.name, ".stall_cycles"}, 32'(stalls), 32'(v.e_st));
      drive_bubble(1'b0);
      e = sb_q.pop_front();
      chk({e.name, ".RegWrite_out"}, 32'(RegWrite_out), 32'(e.e_rw));
      chk({e.name, ".MemtoReg_out"}, 32'(MemtoReg_out), 32'(e.flush ? 1'b0 : e.m2r));
      chk({e.name, ".rd_out"}, 32'(rd_out), 32'(e.flush ? 5'd0 : e.rd));
      chk({e.name, ".Aluout_out"}, Aluout_out, e.flush ? 32'd0 : e.alu);
      chk({e.name, ".c0_out"}, 32'({mtc0_out, mfc0_out}), 32'(e.flush ? 2'b00 : e.c0));
      chk({e.name, ".memdata_out"}, memdata_out, e.e_md);
      chk({e.name, ".exc"}, 32'({adel, ades, bus_err}), 32'(e.e_exc));
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".dm_req"}, 32'(dm_req), 32'd0);
      chk({nm, ".dm_we"}, 32'(dm_we), 32'd0);
      chk({nm, ".dm_addr"}, dm_addr, 32'd0);
      chk({nm, ".dm_be"}, 32'(dm_be), 32'd0);
      chk({nm, ".mem_stall"}, 32'(mem_stall), 32'd0);
      chk({nm, ".wb_ctl"}, 32'({RegWrite_out, MemtoReg_out, mtc0_out, mfc0_out}), 32'd0);
      chk({nm, ".rd_out"}, 32'(rd_out), 32'd0);
      chk({nm, ".Aluout_out"}, Aluout_out, 32'd0);
      chk({nm, ".memdata_out"}, memdata_out, 32'd0);
      chk({nm, ".exc"}, 32'({adel, ades, bus_err}), 32'd0);
   endtask

   initial begin
      //            name        fl    fls   m2r   rw    c0     mw     mr     alu            busb           rd     rdata          lat  req   be       wdata          st  rw    mdata          exc
      tbl.push_back(mk("add",    1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 32'h0000_0005, 32'd0,         5'd3,  32'd0,         -1, 1'b0, 4'b0000, 32'd0,         0, 1'b1, 32'd0,         3'b000));
      tbl.push_back(mk("sb",     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 3'd0, 32'h0000_1003, 32'h0000_00A5, 5'd0,  32'd0,          2, 1'b1, 4'b1000, 32'hA5A5_A5A5, 2, 1'b0, 32'd0,         3'b000));
      tbl.push_back(mk("lb",     1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd1, 32'h0000_2002, 32'd0,         5'd4,  32'h0080_0000,  0, 1'b1, 4'b1111, 32'd0,         0, 1'b1, 32'hFFFF_FF80, 3'b000));
      tbl.push_back(mk("lbu",    1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd2, 32'h0000_2002, 32'd0,         5'd4,  32'h0080_0000,  0, 1'b1, 4'b1111, 32'd0,         0, 1'b1, 32'h0000_0080, 3'b000));
      tbl.push_back(mk("lh",     1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd3, 32'h0000_2002, 32'd0,         5'd4,  32'h8001_0000,  0, 1'b1, 4'b1111, 32'd0,         0, 1'b1, 32'hFFFF_8001, 3'b000));
      tbl.push_back(mk("lhu",    1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd4, 32'h0000_2000, 32'd0,         5'd8,  32'h1234_F00D,  0, 1'b1, 4'b1111, 32'd0,         0, 1'b1, 32'h0000_F00D, 3'b000));
      tbl.push_back(mk("lb3",    1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd1, 32'h0000_2003, 32'd0,         5'd9,  32'h7F00_0000,  0, 1'b1, 4'b1111, 32'd0,         0, 1'b1, 32'h0000_007F, 3'b000));
      tbl.push_back(mk("lw_w1",  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd5, 32'h0000_2004, 32'd0,         5'd11, 32'hCAFE_BABE,  1, 1'b1, 4'b1111, 32'd0,         1, 1'b1, 32'hCAFE_BABE, 3'b000));
      tbl.push_back(mk("sh",     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 3'd0, 32'h0000_2002, 32'h0000_BEEF, 5'd0,  32'd0,          0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 0, 1'b0, 32'd0,         3'b000));
      tbl.push_back(mk("sw",     1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b11, 3'd0, 32'h0000_3000, 32'h1122_3344, 5'd0,  32'd0,          3, 1'b1, 4'b1111, 32'h1122_3344, 3, 1'b0, 32'd0,         3'b000));
      tbl.push_back(mk("lw_mis", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd5, 32'h0000_2001, 32'd0,         5'd12, 32'd0,         -1, 1'b0, 4'b0000, 32'd0,         0, 1'b0, 32'd0,         3'b100));
      tbl.push_back(mk("sh_mis", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 3'd0, 32'h0000_2003, 32'h0000_1234, 5'd0,  32'd0,         -1, 1'b0, 4'b0000, 32'd0,         0, 1'b0, 32'd0,         3'b010));
      tbl.push_back(mk("lh_mis", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd3, 32'h0000_2001, 32'd0,         5'd13, 32'd0,         -1, 1'b0, 4'b0000, 32'd0,         0, 1'b0, 32'd0,         3'b100));
      tbl.push_back(mk("sw_mis", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 3'd0, 32'h0000_1002, 32'h5555_5555, 5'd0,  32'd0,         -1, 1'b0, 4'b0000, 32'd0,         0, 1'b0, 32'd0,         3'b010));
      tbl.push_back(mk("lw_tmo", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd5, 32'h0000_4000, 32'd0,         5'd14, 32'd0,         -1, 1'b1, 4'b1111, 32'd0,        16, 1'b0, 32'd0,         3'b001));
      tbl.push_back(mk("add2",   1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 32'h0000_0042, 32'd0,         5'd15, 32'd0,         -1, 1'b0, 4'b0000, 32'd0,         0, 1'b1, 32'd0,         3'b000));
      tbl.push_back(mk("lw_a16", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 3'd5, 32'h0000_4004, 32'd0,         5'd16, 32'h5A5A_0001, 16, 1'b1, 4'b1111, 32'd0,        16, 1'b1, 32'h5A5A_0001, 3'b000));
      tbl.push_back(mk("noreq",  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 32'h0000_0077, 32'd0,         5'd7,  32'hFFFF_FFFF,  0, 1'b0, 4'b0000, 32'd0,         0, 1'b1, 32'd0,         3'b000));
      tbl.push_back(mk("flush",  1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 3'd0, 32'h0000_0099, 32'd1,         5'd9,  32'd0,         -1, 1'b0, 4'b0000, 32'd0,         0, 1'b0, 32'd0,         3'b000));
      tbl.push_back(mk("mr110",  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'd6, 32'h0000_2001, 32'd0,         5'd10, 32'd0,         -1, 1'b0, 4'b0000, 32'd0,         0, 1'b1, 32'd0,         3'b000));
      tbl.push_back(mk("mfc0",   1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 3'd7, 32'h0000_0012, 32'd0,         5'd2,  32'd0,         -1, 1'b0, 4'b0000, 32'd0,         0, 1'b1, 32'd0,         3'b000));
      tbl.push_back(mk("lw_fls", 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 3'd5, 32'h0000_2008, 32'd0,         5'd5,  32'h0BAD_F00D,  2, 1'b1, 4'b1111, 32'd0,         2, 1'b1, 32'h0BAD_F00D, 3'b000));

      reset = 1'b0;
      dm_ack = 1'b0;
      dm_rdata = 32'd0;
      drive_bubble(1'b0);
      #3;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) run_op(tbl[i]);

      // Asynchronous reset in the middle of a pending load.
      @(negedge clk);
      MemRead = 3'd5; RegWrite = 1'b1; MemtoReg = 1'b1; rd = 5'd6; Aluout = 32'h0000_2010;
      @(posedge clk); #1;
      drive_bubble(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_wait.dm_req", 32'(dm_req), 32'd1);
      chk("rst_wait.mem_stall", 32'(mem_stall), 32'd1);
      #2 reset = 1'b0;
      #1 chk_all_zero("rst_async");
      @(negedge clk);
      reset = 1'b1;
      run_op(tbl[0]);
      run_op(tbl[7]);

      chk("sb_q.empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
